// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
// Program counter, in-order request/response port to instruction memory,
// a DEPTH-entry prefetch queue and a valid/ready port to decode. A redirect
// restarts fetch at an absolute target and drops every queued or in-flight
// fetch. Responses already requested when the redirect arrives are counted
// in 'discard' and thrown away as they return.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]     DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    resp_pc;
  logic [CW-1:0]      q_count;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      discard;
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;

  logic [PC_W-1:0]    q_pc    [DEPTH];
  logic [INSTR_W-1:0] q_instr [DEPTH];

  logic               credit_ok;
  logic               grant;
  logic               push;
  logic               pop;
  logic               q_empty;
  logic               drop_resp;
  logic [CW-1:0]      inflight_after;

  // Circular-buffer pointer advance; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit check, handshakes and output muxing.
  always_comb begin
    // Queued entries plus outstanding requests may never exceed DEPTH, so a
    // returning response always finds a free slot.
    credit_ok      = ({1'b0, q_count} + {1'b0, inflight}) < DEPTH_C;
    imem_req       = rst_n & ~redirect_valid & credit_ok;
    imem_addr      = fetch_pc;
    grant          = imem_req & imem_gnt;
    q_empty        = (q_count == '0);
    drop_resp      = imem_rvalid & (discard != '0);
    // A response arriving in a redirect cycle belongs to the old path.
    push           = imem_rvalid & ~redirect_valid & (discard == '0);
    out_valid      = ~q_empty & ~redirect_valid;
    pop            = out_valid & out_ready;
    out_pc         = q_empty ? '0 : q_pc[head];
    out_instr      = q_empty ? '0 : q_instr[head];
    inflight_after = inflight + CW'(grant) - CW'(imem_rvalid);
  end

  // Control state: PCs, queue pointers and the credit/discard counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      q_count  <= '0;
      inflight <= '0;
      discard  <= '0;
      head     <= '0;
      tail     <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding after this cycle is stale.
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      q_count  <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= inflight_after;
      discard  <= inflight_after;
    end else begin
      inflight <= inflight_after;
      discard  <= discard - CW'(drop_resp);
      q_count  <= q_count + CW'(push) - CW'(pop);
      if (grant) fetch_pc <= fetch_pc + PC_W'(1);
      if (push) begin
        resp_pc <= resp_pc + PC_W'(1);
        tail    <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
    end
  end

  // Queue storage; contents are only meaningful below q_count so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= resp_pc;
      q_instr[tail] <= imem_rdata;
    end
  end

endmodule
